// File: rtl/complex_mac_seq_pkg.sv
// Shared definitions for the sequential complex multiply-accumulate unit:
// FSM state encoding, product-index constants and the per-index tables that
// pick operands, add/subtract and the real/imaginary target.
package complex_mac_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Product index k: which partial product of (a_re + j a_im)(b_re + j b_im)
    localparam logic [1:0] P_RR = 2'd0;  // re += a_re * b_re
    localparam logic [1:0] P_II = 2'd1;  // re -= a_im * b_im
    localparam logic [1:0] P_RI = 2'd2;  // im += a_re * b_im
    localparam logic [1:0] P_IR = 2'd3;  // im += a_im * b_re

    // Only the a_im * b_im term is subtracted
    function automatic logic k_is_sub(input logic [1:0] k);
        return (k == P_II);
    endfunction

    // Cross terms land in the imaginary accumulator
    function automatic logic k_to_im(input logic [1:0] k);
        return (k == P_RI) || (k == P_IR);
    endfunction

    // Multiplier A operand is a_im for these indices, otherwise a_re
    function automatic logic k_a_im(input logic [1:0] k);
        return (k == P_II) || (k == P_IR);
    endfunction

    // Multiplier B operand is b_im for these indices, otherwise b_re
    function automatic logic k_b_im(input logic [1:0] k);
        return (k == P_II) || (k == P_RI);
    endfunction

endpackage

// File: rtl/complex_mac_seq_mult.sv
// Signed W x W -> 2W shift-add multiplier with a start/done handshake.
// Operands are reduced to unsigned magnitudes (the most negative value maps
// to 2^(W-1), which still fits in W bits), multiplied over W shift-add steps
// and negated at the end when the operand signs differ.
// The first step is folded into the load cycle, so a start pulse launched
// at edge m (sampled at m+1) yields product/done at edge m+W. Requires W >= 2.
module seq_signed_mult #(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic                  done,
    output logic signed [2*W-1:0] product
);

    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [CW-1:0]  cnt;
    logic           running;
    logic           neg;

    assign a_mag   = a[W-1] ? $unsigned(-a) : $unsigned(a);
    assign b_mag   = b[W-1] ? $unsigned(-b) : $unsigned(b);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    // Load magnitudes with the first partial product, then shift-add until
    // the counter expires and register the sign-corrected product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            neg     <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else if (start) begin
            mcand   <= {{(W-1){1'b0}}, a_mag, 1'b0};
            mplier  <= {1'b0, b_mag[W-1:1]};
            acc     <= b_mag[0] ? {{W{1'b0}}, a_mag} : '0;
            cnt     <= CW'(W - 1);
            running <= 1'b1;
            neg     <= a[W-1] ^ b[W-1];
            done    <= 1'b0;
        end else if (running) begin
            acc    <= acc_nxt;
            mcand  <= {mcand[2*W-2:0], 1'b0};
            mplier <= {1'b0, mplier[W-1:1]};
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                running <= 1'b0;
                done    <= 1'b1;
                product <= $signed(neg ? -acc_nxt : acc_nxt);
            end else begin
                done <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/complex_mac_seq.sv
// Sequential signed complex multiply-accumulate. Four partial products are
// issued one at a time to a shared shift-add multiplier and summed into work
// registers; the result registers update only when the last product lands.
//
// Handshake: start is sampled only in IDLE or DONE (and only when clr is low);
// it is ignored while busy, with no queueing. busy is high from the accepting
// edge until the edge that enters DONE; done is high for exactly the DONE
// cycle, which is also the first cycle the new out_re/out_im/ovf are visible.
module complex_mac_seq
    import complex_mac_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int ACC_W = 2*W + 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    acc_en,
    input  logic                    clr,
    input  logic signed [W-1:0]     a_re,
    input  logic signed [W-1:0]     a_im,
    input  logic signed [W-1:0]     b_re,
    input  logic signed [W-1:0]     b_im,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] out_re,
    output logic signed [ACC_W-1:0] out_im,
    output logic                    ovf
);

    state_t state_q, state_d;
    logic [1:0] k_q;
    logic signed [W-1:0] ar_q, ai_q, br_q, bi_q;
    logic signed [ACC_W-1:0] work_re, work_im;

    logic idle_like, accept, clear_req;
    logic mult_start, mult_done;
    logic signed [W-1:0]     mult_a, mult_b;
    logic signed [2*W-1:0]   mult_p;
    logic signed [ACC_W-1:0] prod_ext, acc_in, sum, nxt_re, nxt_im;
    logic is_sub, to_im, ov;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign accept    = idle_like && start && !clr;
    assign clear_req = idle_like && clr;

    assign mult_a = k_a_im(k_q) ? ai_q : ar_q;
    assign mult_b = k_b_im(k_q) ? bi_q : br_q;

    seq_signed_mult #(.W(W)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mult_start),
        .a       (mult_a),
        .b       (mult_b),
        .done    (mult_done),
        .product (mult_p)
    );

    // Add or subtract the sign-extended product into the selected work
    // register; signed overflow shows as a sign flip the operands can't explain.
    assign prod_ext = {{(ACC_W-2*W){mult_p[2*W-1]}}, mult_p};
    assign is_sub   = k_is_sub(k_q);
    assign to_im    = k_to_im(k_q);
    assign acc_in   = to_im ? work_im : work_re;
    assign sum      = is_sub ? (acc_in - prod_ext) : (acc_in + prod_ext);
    assign ov       = is_sub
                    ? ((acc_in[ACC_W-1] != prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_in[ACC_W-1]))
                    : ((acc_in[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_in[ACC_W-1]));
    assign nxt_re   = to_im ? work_re : sum;
    assign nxt_im   = to_im ? sum : work_im;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and control outputs
    always_comb begin
        state_d    = state_q;
        mult_start = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                busy       = 1'b1;
                mult_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (mult_done) state_d = ACC;
            end
            ACC: begin
                busy    = 1'b1;
                state_d = (k_q == P_IR) ? DONE : ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = accept ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, product index, work/result registers and sticky ovf
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= P_RR;
            ar_q    <= '0;
            ai_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            work_re <= '0;
            work_im <= '0;
            out_re  <= '0;
            out_im  <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            ar_q    <= a_re;
            ai_q    <= a_im;
            br_q    <= b_re;
            bi_q    <= b_im;
            work_re <= acc_en ? out_re : '0;
            work_im <= acc_en ? out_im : '0;
            if (!acc_en) ovf <= 1'b0;
            k_q     <= P_RR;
        end else if (clear_req) begin
            out_re <= '0;
            out_im <= '0;
            ovf    <= 1'b0;
        end else if (state_q == ACC) begin
            work_re <= nxt_re;
            work_im <= nxt_im;
            if (ov) ovf <= 1'b1;
            // k wraps from P_IR back to P_RR on the commit step
            k_q <= k_q + 2'd1;
            if (k_q == P_IR) begin
                out_re <= nxt_re;
                out_im <= nxt_im;
            end
        end
    end

endmodule

// File: tb/tb_complex_mac_seq.sv
// Bench for complex_mac_seq: two instances (ACC_W=12 and ACC_W=10) share the
// stimulus; a vector table drives single operations and hand-written
// sequences cover back-to-back, reset-abort and clr-vs-start.
module tb_complex_mac_seq;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    logic start, acc_en, clr;
    logic signed [W-1:0] a_re, a_im, b_re, b_im;
    logic busy, done, ovf;
    logic signed [11:0] out_re, out_im;
    logic busy_n, done_n, ovf_n;
    logic signed [9:0] n_re, n_im;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic signed [W-1:0] ar, ai, br, bi;
        logic acc, clr_first;
        int   er, ei, nr, ni;
        logic eo, no;
    } vec_t;

    vec_t tab[14];

    complex_mac_seq #(.W(W), .ACC_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_en(acc_en), .clr(clr),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .busy(busy), .done(done), .out_re(out_re), .out_im(out_im), .ovf(ovf)
    );

    complex_mac_seq #(.W(W), .ACC_W(10)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_en(acc_en), .clr(clr),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .busy(busy_n), .done(done_n), .out_re(n_re), .out_im(n_im), .ovf(ovf_n)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int ar, input int ai, input int br, input int bi,
                                input int acc, input int clrf,
                                input int er, input int ei, input int eo,
                                input int nr, input int ni, input int no);
        vec_t v;
        v.ar = 4'(ar); v.ai = 4'(ai); v.br = 4'(br); v.bi = 4'(bi);
        v.acc = 1'(acc); v.clr_first = 1'(clrf);
        v.er = er; v.ei = ei; v.eo = 1'(eo);
        v.nr = nr; v.ni = ni; v.no = 1'(no);
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for done, counting edges; an expired budget counts as a failure
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        check("done_seen", done, 1);
        check("done_both", done_n, 1);
    endtask

    task automatic drive_ops(input vec_t v);
        a_re = v.ar; a_im = v.ai; b_re = v.br; b_im = v.bi;
        acc_en = v.acc;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        if (v.clr_first) begin
            clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
            check({tag, "_clr_re"}, out_re, 0);
            check({tag, "_clr_ovf"}, ovf, 0);
            check({tag, "_clr_n_re"}, n_re, 0);
            check({tag, "_clr_n_ovf"}, ovf_n, 0);
        end
        drive_ops(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_done(cyc);
        check({tag, "_latency"}, cyc, 24);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_re"}, out_re, v.er);
        check({tag, "_im"}, out_im, v.ei);
        check({tag, "_ovf"}, ovf, v.eo);
        check({tag, "_n_re"}, n_re, v.nr);
        check({tag, "_n_im"}, n_im, v.ni);
        check({tag, "_n_ovf"}, ovf_n, v.no);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int c1, c2;
        logic stable, seen, quiet;

        tab[0]  = mk( 2,  3,  2,  1, 0, 0,    1,   8, 0,    1,   8, 0);
        tab[1]  = mk(-8, -8, -8, -8, 0, 0,    0, 128, 0,    0, 128, 0);
        tab[2]  = mk( 1,  0, -3,  2, 1, 0,   -3, 130, 0,   -3, 130, 0);
        tab[3]  = mk(-8,  0, -8,  0, 1, 1,   64,   0, 0,   64,   0, 0);
        for (int i = 4; i < 10; i++)
            tab[i] = mk(-8, 0, -8, 0, 1, 0, 64*(i-2), 0, 0, 64*(i-2), 0, 0);
        tab[10] = mk(-8,  0, -8,  0, 1, 0,  512,   0, 0, -512,   0, 1);
        tab[11] = mk(-8,  0, -8,  0, 1, 0,  576,   0, 0, -448,   0, 1);
        tab[12] = mk( 7, -1,  3,  5, 0, 0,   26,  32, 0,   26,  32, 0);
        tab[13] = mk(-1,  7, -8, -8, 1, 0,   90, -16, 0,   90, -16, 0);

        // reset
        rst_n = 1'b1; start = 1'b0; acc_en = 1'b0; clr = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_re", out_re, 0);
        check("rst_im", out_im, 0);
        check("rst_ovf", ovf, 0);
        check("rst_n_ovf", ovf_n, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run_vec(tab[i], $sformatf("v%0d", i));

        // clr and start together in IDLE: clr wins, nothing starts
        check("pre_clr_re", out_re, 576);
        check("pre_clr_n_ovf", ovf_n, 1);
        drive_ops(mk(3, 3, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        clr = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        start = 1'b0;
        check("cs_re", out_re, 0);
        check("cs_im", out_im, 0);
        check("cs_ovf", ovf, 0);
        check("cs_n_re", n_re, 0);
        check("cs_n_ovf", ovf_n, 0);
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (busy || done || busy_n) quiet = 1'b0;
            @(posedge clk);
            #1;
        end
        check("cs_no_op", quiet, 1);

        for (int i = 12; i < 14; i++) run_vec(tab[i], $sformatf("v%0d", i));

        // back-to-back with start held high
        drive_ops(mk(2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(c1);
        check("b2b_lat1", c1, 24);
        check("b2b_re1", out_re, 1);
        check("b2b_im1", out_im, 8);
        drive_ops(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("b2b_busy", busy, 1);
        check("b2b_no_done", done, 0);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_ops(mk(7, 7, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0));
            start = (i % 2 == 1);
            @(posedge clk);
            #1;
            if (out_re != 12'sd1 || out_im != 12'sd8 || done) stable = 1'b0;
        end
        start = 1'b0;
        check("b2b_stable", stable, 1);
        wait_done(c2);
        check("b2b_gap", 7 + c2, 25);
        check("b2b_re2", out_re, 1);
        check("b2b_im2", out_im, 10);
        check("b2b_n_im2", n_im, 10);
        @(posedge clk);
        #1;

        // reset in the WAIT of product k=2
        drive_ops(mk(2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("ab_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("ab_busy", busy, 0);
        check("ab_re", out_re, 0);
        check("ab_im", out_im, 0);
        check("ab_ovf", ovf, 0);
        check("ab_n_im", n_im, 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) rst_n = 1'b1;
            if (done || done_n) seen = 1'b1;
        end
        check("ab_no_done", seen, 0);
        run_vec(mk(2, 3, 2, 1, 1, 0, 1, 8, 0, 1, 8, 0), "ab_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
